// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out shift register: one bit captured per clock on sdi,
// the last WIDTH captured bits presented on q directly from the flops.
module sipo_shift_reg #(
  parameter int WIDTH      = 4,
  parameter bit SHIFT_LEFT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sdi,
  output logic [WIDTH-1:0] q
);

  // reset_n is active-high despite its name; the name is kept so existing
  // instantiations continue to connect unchanged.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the shift cannot ripple through the register within one edge.
    if (reset_n) begin
      q <= '0;
    end else if (SHIFT_LEFT) begin
      q <= {q[WIDTH-2:0], sdi};
    end else begin
      q <= {sdi, q[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Self-checking bench for sipo_shift_reg: a default right-shifting 4-bit instance
// and an 8-bit left-shifting instance, both checked against a bit-history model.
module tb_sipo_shift_reg;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sdi = 1'b0;
  logic [3:0] q4;
  logic [7:0] q8;

  int total = 0;
  int bad   = 0;

  // Captured bits, newest first; reset means the last eight captured bits are zero.
  logic hist[$];

  always #5 clk = ~clk;

  sipo_shift_reg u_dut4 (
    .clk    (clk),
    .reset_n(reset_n),
    .sdi    (sdi),
    .q      (q4)
  );

  sipo_shift_reg #(.WIDTH(8), .SHIFT_LEFT(1'b1)) u_dut8 (
    .clk    (clk),
    .reset_n(reset_n),
    .sdi    (sdi),
    .q      (q8)
  );

  // Right shift: the newest bit sits at the MSB, older bits toward the LSB.
  function automatic logic [3:0] model4();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[3-k] = hist[k];
    return r;
  endfunction

  // Left shift: the newest bit sits at the LSB, older bits toward the MSB.
  function automatic logic [7:0] model8();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = hist[k];
    return r;
  endfunction

  // Apply one edge worth of inputs, then sample #1 after the edge.
  task automatic step(input logic rst, input logic d);
    reset_n = rst;
    sdi     = d;
    @(posedge clk);
    #1;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < 8; k++) hist.push_back(1'b0);
    end else begin
      hist.push_front(d);
      void'(hist.pop_back());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    total++;
    if (q4[3:1] !== 3'b111) begin
      bad++;
      $display("FAIL reset_prefill4: got %b want 111x", q4);
    end
    total++;
    if (q8[2:0] !== 3'b111) begin
      bad++;
      $display("FAIL reset_prefill8: got %b want xxxxx111", q8);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      total++;
      if (q4 !== 4'b0000 || q8 !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got q4=%b q8=%b want 0000 00000000", i, q4, q8);
      end
    end
  endtask

  task automatic test_single_walk();
    logic [3:0] exp_tab [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i == 0));
      total++;
      if (q4 !== exp_tab[i] || q4 !== model4()) begin
        bad++;
        $display("FAIL single_walk[%0d]: got %b want %b", i, q4, exp_tab[i]);
      end
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_tab [6] = '{4'b1000, 4'b1100, 4'b0110, 4'b0011, 4'b0001, 4'b0000};
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i < 2));
      total++;
      if (q4 !== exp_tab[i] || q4 !== model4()) begin
        bad++;
        $display("FAIL burst[%0d]: got %b want %b", i, q4, exp_tab[i]);
      end
    end
  endtask

  task automatic test_pattern();
    logic [3:0] exp_tab [4] = '{4'b1000, 4'b0100, 4'b1010, 4'b0101};
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i % 2 == 0));
      total++;
      if (q4 !== exp_tab[i]) begin
        bad++;
        $display("FAIL pattern1010[%0d]: got %b want %b", i, q4, exp_tab[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    total++;
    if (q4 !== 4'b1100) begin
      bad++;
      $display("FAIL mid_reset_pre: got %b want 1100", q4);
    end
    step(1'b1, 1'b1);
    total++;
    if (q4 !== 4'b0000 || q8 !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_clear: got q4=%b q8=%b want 0000 00000000", q4, q8);
    end
    step(1'b0, 1'b1);
    total++;
    if (q4 !== 4'b1000 || q8 !== 8'b0000_0001) begin
      bad++;
      $display("FAIL mid_reset_resume: got q4=%b q8=%b want 1000 00000001", q4, q8);
    end
  endtask

  task automatic test_wide_variant();
    logic [7:0] pat = 8'b1011_0010;
    step(1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) step(1'b0, pat[i]);
    total++;
    if (q8 !== 8'b1011_0010 || q8 !== model8()) begin
      bad++;
      $display("FAIL wide_word: got %b want 10110010", q8);
    end
    step(1'b0, 1'b0);
    total++;
    if (q8 !== 8'b0110_0100) begin
      bad++;
      $display("FAIL wide_extra: got %b want 01100100", q8);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1);
      total++;
      if (q4 !== model4() || q8 !== model8()) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL random[%0d]: got q4=%b q8=%b want %b %b",
                   i, q4, q8, model4(), model8());
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) hist.push_back(1'b0);
    test_reset();
    test_single_walk();
    test_burst();
    test_pattern();
    test_mid_reset();
    test_wide_variant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
